// File: rtl/ram_pkg.sv
// ram_pkg: shared helpers for the banked RAM.
//   bank_of / word_of split a flat address into bank index and in-bank word index
//   (low address bits select the bank, so consecutive addresses interleave across banks).
//   is_pow2 / lat_ok back the parameter checks in ram_banked.
package ram_pkg;

    localparam int unsigned RD_LAT_MAX = 2;

    function automatic bit is_pow2(input int unsigned n);
        return (n != 0) && ((n & (n - 1)) == 0);
    endfunction

    function automatic bit lat_ok(input int unsigned lat);
        return (lat >= 1) && (lat <= RD_LAT_MAX);
    endfunction

    // Number of address bits that actually select a bank (0 for a single bank).
    function automatic int unsigned bank_bits(input int unsigned num_bank);
        return (num_bank > 1) ? $clog2(num_bank) : 0;
    endfunction

    function automatic logic [31:0] bank_of(input logic [31:0] addr, input int unsigned num_bank);
        return (num_bank > 1) ? (addr & (num_bank - 1)) : 32'd0;
    endfunction

    // With one bank no bits are consumed by bank select, so the whole address is the word.
    function automatic logic [31:0] word_of(input logic [31:0] addr, input int unsigned num_bank);
        return addr >> bank_bits(num_bank);
    endfunction

endpackage

// File: rtl/ram_bank.sv
// ram_bank: one behavioural SRAM bank; the single place to swap in a hard macro.
//   clk           clock
//   we/waddr/be/wdat  byte-enabled write
//   re/raddr      read request; rdat is registered (valid the cycle after re)
// DUAL_PORT=1: independent read and write ports, read-first on a same-address collision.
// DUAL_PORT=0: one shared address, write has priority (the read is ignored if we=1).
module ram_bank #(
    parameter int unsigned SRAM_BIT   = 8,
    parameter int unsigned SRAM_BYTE  = 32,
    parameter int unsigned SRAM_WORD  = 64,
    parameter int unsigned DUAL_PORT  = 0,
    parameter int unsigned SRAM_WIDTH = SRAM_BIT * SRAM_BYTE,
    parameter int unsigned WORD_WIDTH = (SRAM_WORD > 1) ? $clog2(SRAM_WORD) : 1
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [WORD_WIDTH-1:0] waddr,
    input  logic [SRAM_BYTE-1:0]  be,
    input  logic [SRAM_WIDTH-1:0] wdat,
    input  logic                  re,
    input  logic [WORD_WIDTH-1:0] raddr,
    output logic [SRAM_WIDTH-1:0] rdat
);

    logic [SRAM_BYTE-1:0][SRAM_BIT-1:0] mem [SRAM_WORD];

    logic [WORD_WIDTH-1:0] wr_idx;
    logic [WORD_WIDTH-1:0] rd_idx;
    logic                  rd_en;

    if (DUAL_PORT != 0) begin : g_dp
        assign wr_idx = waddr;
        assign rd_idx = raddr;
        assign rd_en  = re;
    end else begin : g_sp
        logic [WORD_WIDTH-1:0] port_addr;
        assign port_addr = we ? waddr : raddr;
        assign wr_idx    = port_addr;
        assign rd_idx    = port_addr;
        assign rd_en     = re && !we;
    end

    // Non-blocking read and write of the same word gives read-first behaviour.
    always_ff @(posedge clk) begin
        for (int i = 0; i < SRAM_BYTE; i++) begin
            if (we && be[i]) begin
                mem[wr_idx][i] <= wdat[i*SRAM_BIT +: SRAM_BIT];
            end
        end
        if (rd_en) begin
            rdat <= mem[rd_idx];
        end
    end

endmodule

// File: rtl/ram_banked.sv
// ram_banked: one write port and one read port over NUM_BANK address-interleaved banks.
//   clk, rst            clock, synchronous active-high reset
//   wr_vld/wr_rdy       write handshake (wr_rdy is always 1)
//   wr_addr/wr_be/wr_dat  write address, byte enables, data
//   rd_vld/rd_rdy       read handshake; rd_rdy drops on a bank conflict in single-port mode
//   rd_addr             read address
//   rd_dat_vld/rd_dat   one-cycle result pulse; rd_dat holds the last result between pulses
module ram_banked
    import ram_pkg::*;
#(
    parameter int unsigned SRAM_BIT       = 8,
    parameter int unsigned SRAM_BYTE      = 32,
    parameter int unsigned SRAM_WORD      = 64,
    parameter int unsigned NUM_BANK       = 4,
    parameter int unsigned DUAL_PORT      = 0,
    parameter int unsigned RD_LAT         = 1,
    parameter int unsigned SRAM_WIDTH     = SRAM_BIT * SRAM_BYTE,
    parameter int unsigned BANK_SEL_WIDTH = (NUM_BANK > 1) ? $clog2(NUM_BANK) : 1,
    parameter int unsigned ADDR_WIDTH     = $clog2(SRAM_WORD * NUM_BANK)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_vld,
    output logic                  wr_rdy,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [SRAM_BYTE-1:0]  wr_be,
    input  logic [SRAM_WIDTH-1:0] wr_dat,
    input  logic                  rd_vld,
    output logic                  rd_rdy,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_dat_vld,
    output logic [SRAM_WIDTH-1:0] rd_dat
);

    localparam int unsigned WORD_WIDTH = (SRAM_WORD > 1) ? $clog2(SRAM_WORD) : 1;

    if (!is_pow2(NUM_BANK)) begin : g_bad_num_bank
        $error("ram_banked: NUM_BANK must be a power of two");
    end
    if (!lat_ok(RD_LAT)) begin : g_bad_rd_lat
        $error("ram_banked: RD_LAT must be 1 or 2");
    end

    logic [BANK_SEL_WIDTH-1:0] wr_bank;
    logic [BANK_SEL_WIDTH-1:0] rd_bank;
    logic [WORD_WIDTH-1:0]     wr_word;
    logic [WORD_WIDTH-1:0]     rd_word;

    assign wr_bank = BANK_SEL_WIDTH'(bank_of(32'(wr_addr), NUM_BANK));
    assign rd_bank = BANK_SEL_WIDTH'(bank_of(32'(rd_addr), NUM_BANK));
    assign wr_word = WORD_WIDTH'(word_of(32'(wr_addr), NUM_BANK));
    assign rd_word = WORD_WIDTH'(word_of(32'(rd_addr), NUM_BANK));

    assign wr_rdy = 1'b1;
    // Write wins a conflict; deliberately independent of rd_vld.
    assign rd_rdy = (DUAL_PORT != 0) ? 1'b1 : !(wr_vld && (wr_bank == rd_bank));

    logic                  rd_fire;
    logic [NUM_BANK-1:0]   bank_we;
    logic [NUM_BANK-1:0]   bank_re;
    logic [SRAM_WIDTH-1:0] bank_rdat [NUM_BANK];

    assign rd_fire = rd_vld && rd_rdy;

    always_comb begin
        bank_we = '0;
        bank_re = '0;
        for (int b = 0; b < NUM_BANK; b++) begin
            bank_we[b] = wr_vld && (wr_bank == BANK_SEL_WIDTH'(b));
            bank_re[b] = rd_fire && (rd_bank == BANK_SEL_WIDTH'(b));
        end
    end

    for (genvar b = 0; b < NUM_BANK; b++) begin : g_bank
        ram_bank #(
            .SRAM_BIT  (SRAM_BIT),
            .SRAM_BYTE (SRAM_BYTE),
            .SRAM_WORD (SRAM_WORD),
            .DUAL_PORT (DUAL_PORT)
        ) u_bank (
            .clk   (clk),
            .we    (bank_we[b]),
            .waddr (wr_word),
            .be    (wr_be),
            .wdat  (wr_dat),
            .re    (bank_re[b]),
            .raddr (rd_word),
            .rdat  (bank_rdat[b])
        );
    end

    // First pipe stage tracks the bank RAM read: valid plus which bank to steer from.
    logic                      vld_q1;
    logic [BANK_SEL_WIDTH-1:0] bank_q1;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q1  <= 1'b0;
            bank_q1 <= '0;
        end else begin
            vld_q1 <= rd_fire;
            if (rd_fire) begin
                bank_q1 <= rd_bank;
            end
        end
    end

    logic [SRAM_WIDTH-1:0] bank_mux;

    always_comb begin
        bank_mux = '0;
        for (int b = 0; b < NUM_BANK; b++) begin
            if (bank_q1 == BANK_SEL_WIDTH'(b)) begin
                bank_mux = bank_rdat[b];
            end
        end
    end

    logic                  out_vld;
    logic [SRAM_WIDTH-1:0] out_dat;

    if (RD_LAT == 2) begin : g_lat2
        logic                  vld_q2;
        logic [SRAM_WIDTH-1:0] dat_q2;

        always_ff @(posedge clk) begin
            if (rst) begin
                vld_q2 <= 1'b0;
                dat_q2 <= '0;
            end else begin
                vld_q2 <= vld_q1;
                if (vld_q1) begin
                    dat_q2 <= bank_mux;
                end
            end
        end

        assign out_vld = vld_q2;
        assign out_dat = dat_q2;
    end else begin : g_lat1
        assign out_vld = vld_q1;
        assign out_dat = bank_mux;
    end

    logic [SRAM_WIDTH-1:0] hold_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q <= '0;
        end else if (out_vld) begin
            hold_q <= out_dat;
        end
    end

    assign rd_dat_vld = out_vld;
    assign rd_dat     = out_vld ? out_dat : hold_q;

endmodule

// File: tb/tb_ram_banked.sv
// Bench for ram_banked: two instances on shared stimulus,
//   dut_a: DUAL_PORT=0, RD_LAT=1   dut_b: DUAL_PORT=1, RD_LAT=2
// Inputs change on the falling edge; outputs are sampled on the falling edge before the
// new inputs are applied, and rd_rdy is sampled 1 ns after the inputs change.
module tb_ram_banked;

    localparam int unsigned W  = 256;
    localparam int unsigned AW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_vld;
    logic [AW-1:0] wr_addr;
    logic [31:0]   wr_be;
    logic [W-1:0]  wr_dat;
    logic          rd_vld;
    logic [AW-1:0] rd_addr;

    logic          a_wr_rdy, a_rd_rdy, a_vld;
    logic [W-1:0]  a_dat;
    logic          b_wr_rdy, b_rd_rdy, b_vld;
    logic [W-1:0]  b_dat;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    ram_banked #(.NUM_BANK(4), .DUAL_PORT(0), .RD_LAT(1)) dut_a (
        .clk        (clk),
        .rst        (rst),
        .wr_vld     (wr_vld),
        .wr_rdy     (a_wr_rdy),
        .wr_addr    (wr_addr),
        .wr_be      (wr_be),
        .wr_dat     (wr_dat),
        .rd_vld     (rd_vld),
        .rd_rdy     (a_rd_rdy),
        .rd_addr    (rd_addr),
        .rd_dat_vld (a_vld),
        .rd_dat     (a_dat)
    );

    ram_banked #(.NUM_BANK(4), .DUAL_PORT(1), .RD_LAT(2)) dut_b (
        .clk        (clk),
        .rst        (rst),
        .wr_vld     (wr_vld),
        .wr_rdy     (b_wr_rdy),
        .wr_addr    (wr_addr),
        .wr_be      (wr_be),
        .wr_dat     (wr_dat),
        .rd_vld     (rd_vld),
        .rd_rdy     (b_rd_rdy),
        .rd_addr    (rd_addr),
        .rd_dat_vld (b_vld),
        .rd_dat     (b_dat)
    );

    typedef struct {
        logic         wv;
        logic [7:0]   wa;
        logic [31:0]  be;
        logic [7:0]   wb;
        logic         rv;
        logic [7:0]   ra;
        logic         rdy_a;
        logic         rdy_b;
        logic         va;
        logic [W-1:0] da;
        logic         vb;
        logic [W-1:0] db;
    } vec_t;

    localparam logic [31:0] ALL = 32'hFFFF_FFFF;

    function automatic logic [W-1:0] rep(input logic [7:0] b);
        return {32{b}};
    endfunction

    function automatic vec_t mkv(input logic wv, input logic [7:0] wa, input logic [31:0] be,
                                 input logic [7:0] wb, input logic rv, input logic [7:0] ra,
                                 input logic rdy_a, input logic rdy_b,
                                 input logic va, input logic [W-1:0] da,
                                 input logic vb, input logic [W-1:0] db);
        vec_t v;
        v.wv = wv; v.wa = wa; v.be = be; v.wb = wb; v.rv = rv; v.ra = ra;
        v.rdy_a = rdy_a; v.rdy_b = rdy_b; v.va = va; v.da = da; v.vb = vb; v.db = db;
        return v;
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic wv, input logic [7:0] wa, input logic [31:0] be,
                         input logic [7:0] wb, input logic rv, input logic [7:0] ra);
        wr_vld  = wv;
        wr_addr = wa;
        wr_be   = be;
        wr_dat  = rep(wb);
        rd_vld  = rv;
        rd_addr = ra;
    endtask

    task automatic idle();
        drive(1'b0, 8'd0, 32'd0, 8'd0, 1'b0, 8'd0);
    endtask

    task automatic chk_out(input string tag, input logic va, input logic [W-1:0] da,
                           input logic vb, input logic [W-1:0] db);
        chk({tag, " a_vld"}, W'(a_vld), W'(va));
        chk({tag, " a_dat"}, a_dat, da);
        chk({tag, " b_vld"}, W'(b_vld), W'(vb));
        chk({tag, " b_dat"}, b_dat, db);
    endtask

    vec_t         vecs [19];
    logic [W-1:0] x_lane;
    logic [W-1:0] z;

    initial begin
        x_lane = {{31{8'hAA}}, 8'h55};
        z      = '0;

        // Lane write, bank conflict, read-first, byte-enable no-op.
        vecs[0]  = mkv(1, 5, ALL, 8'hAA, 0, 0, 1, 1, 0, z,         0, z);
        vecs[1]  = mkv(1, 5, 1,   8'h55, 0, 0, 1, 1, 0, z,         0, z);
        vecs[2]  = mkv(0, 0, 0,   8'h00, 1, 5, 1, 1, 0, z,         0, z);
        vecs[3]  = mkv(1, 3, ALL, 8'h11, 0, 0, 1, 1, 1, x_lane,    0, z);
        vecs[4]  = mkv(1, 8, ALL, 8'h77, 0, 0, 0, 1, 0, x_lane,    1, x_lane);
        vecs[5]  = mkv(1, 9, ALL, 8'h99, 0, 0, 1, 1, 0, x_lane,    0, x_lane);
        vecs[6]  = mkv(1, 4, ALL, 8'hCC, 1, 8, 0, 1, 0, x_lane,    0, x_lane);
        vecs[7]  = mkv(0, 0, 0,   8'h00, 1, 8, 1, 1, 0, x_lane,    0, x_lane);
        vecs[8]  = mkv(1, 4, ALL, 8'hDD, 1, 9, 1, 1, 1, rep(8'h77), 1, rep(8'h77));
        vecs[9]  = mkv(0, 0, 0,   8'h00, 0, 0, 1, 1, 1, rep(8'h99), 1, rep(8'h77));
        vecs[10] = mkv(0, 0, 0,   8'h00, 0, 0, 1, 1, 0, rep(8'h99), 1, rep(8'h99));
        vecs[11] = mkv(1, 3, ALL, 8'h22, 1, 3, 0, 1, 0, rep(8'h99), 0, rep(8'h99));
        vecs[12] = mkv(0, 0, 0,   8'h00, 1, 3, 1, 1, 0, rep(8'h99), 0, rep(8'h99));
        vecs[13] = mkv(0, 0, 0,   8'h00, 0, 0, 1, 1, 1, rep(8'h22), 1, rep(8'h11));
        vecs[14] = mkv(0, 0, 0,   8'h00, 0, 0, 1, 1, 0, rep(8'h22), 1, rep(8'h22));
        vecs[15] = mkv(1, 5, 0,   8'hFF, 0, 0, 1, 1, 0, rep(8'h22), 0, rep(8'h22));
        vecs[16] = mkv(0, 0, 0,   8'h00, 1, 5, 1, 1, 0, rep(8'h22), 0, rep(8'h22));
        vecs[17] = mkv(0, 0, 0,   8'h00, 0, 0, 1, 1, 1, x_lane,    0, rep(8'h22));
        vecs[18] = mkv(0, 0, 0,   8'h00, 0, 0, 1, 1, 0, x_lane,    1, x_lane);

        rst = 1'b1;
        idle();
        repeat (2) @(negedge clk);
        rst = 1'b0;

        chk("reset a_wr_rdy", W'(a_wr_rdy), W'(1'b1));
        chk("reset b_wr_rdy", W'(b_wr_rdy), W'(1'b1));

        for (int k = 0; k < 19; k++) begin
            @(negedge clk);
            chk_out($sformatf("row%0d", k), vecs[k].va, vecs[k].da, vecs[k].vb, vecs[k].db);
            drive(vecs[k].wv, vecs[k].wa, vecs[k].be, vecs[k].wb, vecs[k].rv, vecs[k].ra);
            #1;
            chk($sformatf("row%0d a_rd_rdy", k), W'(a_rd_rdy), W'(vecs[k].rdy_a));
            chk($sformatf("row%0d b_rd_rdy", k), W'(b_rd_rdy), W'(vecs[k].rdy_b));
        end

        // Streaming: fill addr 0..15, then 16 back-to-back reads across all banks.
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            drive(1'b1, 8'(i), ALL, 8'(8'h40 + i), 1'b0, 8'd0);
        end
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk($sformatf("stream%0d a_vld", c), W'(a_vld), W'((c >= 1) && (c <= 16)));
            chk($sformatf("stream%0d b_vld", c), W'(b_vld), W'((c >= 2) && (c <= 17)));
            if (c >= 1 && c <= 16) chk($sformatf("stream%0d a_dat", c), a_dat, rep(8'(8'h40 + c - 1)));
            if (c >= 2 && c <= 17) chk($sformatf("stream%0d b_dat", c), b_dat, rep(8'(8'h40 + c - 2)));
            if (c < 16) drive(1'b0, 8'd0, 32'd0, 8'd0, 1'b1, 8'(c));
            else        idle();
        end

        // Hold register across idle cycles.
        @(negedge clk); drive(1'b1, 8'd6, ALL, 8'h33, 1'b0, 8'd0);
        @(negedge clk); drive(1'b0, 8'd0, 32'd0, 8'h00, 1'b1, 8'd6);
        @(negedge clk); idle();
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk_out($sformatf("hold%0d", i), 1'b0, rep(8'h33), 1'b0, rep(8'h33));
        end

        // Reset with reads in flight: b's read is mid-pipe, a's read coincides with rst.
        drive(1'b0, 8'd0, 32'd0, 8'h00, 1'b1, 8'd6);
        @(negedge clk);
        chk_out("rst_pre", 1'b1, rep(8'h33), 1'b0, rep(8'h33));
        rst = 1'b1;
        @(negedge clk);
        chk_out("rst0", 1'b0, z, 1'b0, z);
        rst = 1'b0;
        idle();
        for (int i = 1; i < 3; i++) begin
            @(negedge clk);
            chk_out($sformatf("rst%0d", i), 1'b0, z, 1'b0, z);
        end

        // Memory survives reset.
        drive(1'b0, 8'd0, 32'd0, 8'h00, 1'b1, 8'd6);
        @(negedge clk);
        idle();
        chk_out("post_rst1", 1'b1, rep(8'h33), 1'b0, z);
        @(negedge clk);
        chk_out("post_rst2", 1'b0, rep(8'h33), 1'b1, rep(8'h33));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ram_banked.md
# ram_banked

Parametrised, multi-bank successor to the single-bank SRAM wrapper: presents one write port and one read port over `NUM_BANK` address-interleaved banks, with per-byte write enables, a valid/ready request handshake, bank-conflict stalling in single-port mode, configurable read latency and a read-data hold register. Sits between the global buffer controllers and the physical SRAM banks. Replaces hand-instantiated per-bank wrappers in GLB and shuffle storage.

## Interface
- `SRAM_BIT`, 8: bits per byte lane.
- `SRAM_BYTE`, 32: byte lanes per word.
- `SRAM_WORD`, 64: words per bank.
- `NUM_BANK`, 4: bank count; power of two, ≥1.
- `DUAL_PORT`, 0: 0 = each bank single-port; 1 = each bank has an independent read port and write port.
- `RD_LAT`, 1: read latency in cycles, 1 or 2.
- Derived: `SRAM_WIDTH` = SRAM_BIT*SRAM_BYTE; `BANK_SEL_WIDTH` = max(1, clog2(NUM_BANK)); `ADDR_WIDTH` = clog2(SRAM_WORD*NUM_BANK).

Ports:
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `wr_vld` in 1: write request.
- `wr_rdy` out 1: constant 1; writes are never stalled.
- `wr_addr` in ADDR_WIDTH: write address.
- `wr_be` in SRAM_BYTE: byte enables, 1 = write lane.
- `wr_dat` in SRAM_WIDTH: write data.
- `rd_vld` in 1: read request.
- `rd_rdy` out 1: read request accepted this cycle.
- `rd_addr` in ADDR_WIDTH: read address.
- `rd_dat_vld` out 1: one-cycle pulse, `rd_dat` is new.
- `rd_dat` out SRAM_WIDTH: read data, held between reads.

## Operation
- Mapping: bank = addr[BANK_SEL_WIDTH-1:0]; word = addr >> BANK_SEL_WIDTH. With NUM_BANK=1, bank is always 0.
- Write fires when `wr_vld`=1. Only lanes with `wr_be[i]`=1 update; `wr_be`=0 is a legal no-op.
- Read fires when `rd_vld && rd_rdy`.
- `rd_rdy` in DUAL_PORT=1: constant 1.
- `rd_rdy` in DUAL_PORT=0: `!(wr_vld && bank(wr_addr)==bank(rd_addr))`. Write wins a bank conflict; the requester holds `rd_vld` and `rd_addr` until accepted.
- `rd_rdy` is combinational from `wr_vld`, `wr_addr` and `rd_addr` only. It never depends on `rd_vld`.
- Same-address read and write in the same cycle (DUAL_PORT=1 only): read-first, so the read returns the old data.
- The accepted bank index is pipelined alongside the request and steers the output mux. Outstanding reads: at most RD_LAT.
- Hold register: on every `rd_dat_vld` pulse it captures the muxed data. `rd_dat` = `rd_dat_vld` ? muxed data : hold register.
- Reset clears the pipeline valids, bank-index pipe and hold register. In-flight reads are discarded. Memory contents are not cleared.

## Timing
- Reset values: `rd_dat_vld`=0, `rd_dat`=0, `rd_rdy` per the combinational rule, `wr_rdy`=1.
- RD_LAT=1: read accepted at cycle N gives `rd_dat_vld`=1 at N+1.
- RD_LAT=2: read accepted at cycle N gives `rd_dat_vld`=1 at N+2, via an output register stage.
- Write at N is visible to a read accepted at N+1 or later.
- Back-to-back reads give one result per cycle, in order, across any mix of banks.
- `rst` asserted at cycle N forces `rd_dat_vld`=0 from N+1 until a new read completes. Reads accepted in the same cycle as `rst` are dropped.

## Structure
- Package `ram_pkg`:
  - function `bank_of(addr)` and function `word_of(addr)`;
  - localparam `RD_LAT_MAX`=2;
  - elaboration checks: NUM_BANK power of two; RD_LAT in {1,2}.
- Sub-module `ram_bank`: one behavioural bank with byte-enable write and read-first read. Separate read and write ports when DUAL_PORT=1; one shared address with write priority when DUAL_PORT=0. Instantiated NUM_BANK times in a generate loop. It is the only place a macro swap happens.

## Test plan
- Lane write then read: write 0xAA.. with all `wr_be` set to addr 5, write 0x55.. with `wr_be`=0x1 to addr 5, read addr 5. Expect byte 0 = 0x55 and all other bytes 0xAA at RD_LAT.
- Bank conflict, DUAL_PORT=0, NUM_BANK=4: `wr_vld` to addr 4 with `rd_vld` at addr 8 (both bank 0) gives `rd_rdy`=0. With `rd_vld` at addr 9 (bank 1), `rd_rdy`=1 and data returns at RD_LAT.
- Read-first, DUAL_PORT=1: addr 3 holds 0x11.., then write 0x22.. and read addr 3 in the same cycle. Expect 0x11..; a read on the next cycle returns 0x22...
- Streaming, RD_LAT=2: 16 consecutive reads over addr 0..15. Expect 16 consecutive `rd_dat_vld` pulses starting 2 cycles after the first accept, with data in order.
- Hold and reset: after a read returns 0x33.., idle 5 cycles; `rd_dat` stays 0x33... Assert `rst` with a read in flight: no `rd_dat_vld`, `rd_dat`=0. Memory still holds 0x33.. on a later read.
